// File: rtl/bcd_seq_if.sv
// Handshake bundle between a requester and the binary-to-BCD converter.
// The requester drives start/bin_in; the converter answers with ready,
// a one-cycle done pulse, the packed BCD word and the overflow flag.
interface bcd_seq_if #(
    parameter int IN_W   = 18,
    parameter int DIGITS = 8
);
    logic                  start;
    logic [IN_W-1:0]       bin_in;
    logic                  ready;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd_out;
    logic                  ovf;

    modport master (
        output start, bin_in,
        input  ready, done, bcd_out, ovf
    );

    modport slave (
        input  start, bin_in,
        output ready, done, bcd_out, ovf
    );
endinterface

// File: rtl/bcd_seq_converter.sv
// Iterative binary-to-BCD converter (shift-add-3 / double dabble).
// One input bit is consumed per SHIFT cycle; after IN_W shifts a DONE
// cycle publishes the scratch digits (or all nines on overflow).
// Optional feature macro: BCD_BLANK_EN -- when defined, leading zero
// digits above digit 0 are replaced by 4'hF (hexdriver blank code),
// except on overflow. Undefined (default): raw BCD with zeros shown.
module bcd_seq_converter #(
    parameter int IN_W   = 18,
    parameter int DIGITS = 8
) (
    input  logic       clk2,
    input  logic       rst,
    bcd_seq_if.slave   bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(IN_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [IN_W-1:0]    shreg_q, shreg_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic               sticky_q, sticky_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;

    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   result;
    logic               shift_out;

    // Add 3 to every scratch digit that is 5 or more, ahead of the shift.
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
        end
    end

`ifdef BCD_BLANK_EN
    logic lead;

    // Display word: all nines on overflow, else digits with leading zeros blanked.
    always_comb begin
        result = sticky_q ? {DIGITS{4'h9}} : scratch_q;
        lead   = 1'b1;
        if (!sticky_q) begin
            for (int i = DIGITS - 1; i > 0; i--) begin
                if (lead && scratch_q[4*i +: 4] == 4'h0)
                    result[4*i +: 4] = 4'hF;
                else
                    lead = 1'b0;
            end
        end
    end
`else
    // Display word: all nines on overflow, else the raw BCD digits.
    always_comb begin
        result = sticky_q ? {DIGITS{4'h9}} : scratch_q;
    end
`endif

    // Next-state and datapath update for the IDLE -> SHIFT -> DONE sequence.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; that is what keeps this block free of latches.
        state_d   = state_q;
        shreg_d   = shreg_q;
        scratch_d = scratch_q;
        sticky_d  = sticky_q;
        count_d   = count_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        shift_out = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    shreg_d   = bus.bin_in;
                    scratch_d = '0;
                    sticky_d  = 1'b0;
                    count_d   = CNT_W'(IN_W);
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                {shift_out, scratch_d, shreg_d} = {adj, shreg_q, 1'b0};
                sticky_d = sticky_q | shift_out;
                count_d  = count_q - 1'b1;
                if (count_q == CNT_W'(1))
                    state_d = S_DONE;
            end
            S_DONE: begin
                bcd_d   = result;
                ovf_d   = sticky_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; synchronous active-low reset discards any conversion.
    always_ff @(posedge clk2) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values computed above, independent of statement order.
        if (!rst) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            scratch_q <= '0;
            sticky_q  <= 1'b0;
            count_q   <= '0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            scratch_q <= scratch_d;
            sticky_q  <= sticky_d;
            count_q   <= count_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    assign bus.ready   = (state_q == S_IDLE);
    assign bus.done    = done_q;
    assign bus.bcd_out = bcd_q;
    assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_bcd_seq_converter.sv
// Scoreboard bench for bcd_seq_converter: an 8-digit and a 4-digit instance
// share the same start/bin_in stimulus. A predictor pushes decimal results
// computed arithmetically; a monitor pops them on every done pulse.
module tb_bcd_seq_converter;
    localparam int IN_W = 18;
    localparam int LAT  = IN_W + 1;
    localparam int GAP  = IN_W + 2;

    typedef struct {
        logic [31:0] bcd;
        logic        ovf;
        int          acc;
    } exp_t;

    logic            clk2 = 1'b0;
    logic            rst;
    logic            start;
    logic [IN_W-1:0] bin;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   next_free = 0;
    logic out_of_reset = 1'b0;
    logic rst_at_edge = 1'b0;
    logic [31:0] prev8, prev4;

    exp_t exp8_q[$];
    exp_t exp4_q[$];

    bcd_seq_if #(.IN_W(IN_W), .DIGITS(8)) if8 ();
    bcd_seq_if #(.IN_W(IN_W), .DIGITS(4)) if4 ();

    assign if8.start  = start;
    assign if8.bin_in = bin;
    assign if4.start  = start;
    assign if4.bin_in = bin;

    bcd_seq_converter #(.IN_W(IN_W), .DIGITS(8)) dut8 (
        .clk2 (clk2),
        .rst  (rst),
        .bus  (if8)
    );

    bcd_seq_converter #(.IN_W(IN_W), .DIGITS(4)) dut4 (
        .clk2 (clk2),
        .rst  (rst),
        .bus  (if4)
    );

    always #5 clk2 = ~clk2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    // Decimal reference: digit i is (v / 10^i) % 10; overflow shows all nines.
    function automatic exp_t model(input int unsigned v, input int digits, input int acc);
        exp_t        e;
        int unsigned lim;
        int unsigned t;
        bit          lead;
        lim = 1;
        for (int i = 0; i < digits; i++) lim = lim * 10;
        e.bcd = '0;
        e.acc = acc;
        if (v >= lim) begin
            e.ovf = 1'b1;
            for (int i = 0; i < digits; i++) e.bcd[4*i +: 4] = 4'h9;
        end else begin
            e.ovf = 1'b0;
            t = v;
            for (int i = 0; i < digits; i++) begin
                e.bcd[4*i +: 4] = 4'(t % 10);
                t = t / 10;
            end
`ifdef BCD_BLANK_EN
            lead = 1'b1;
            for (int i = digits - 1; i > 0; i--) begin
                if (lead && e.bcd[4*i +: 4] == 4'h0) e.bcd[4*i +: 4] = 4'hF;
                else lead = 1'b0;
            end
`else
            lead = 1'b0;
`endif
        end
        return e;
    endfunction

    // Predictor: models the busy window, checks ready, and queues expectations.
    always @(posedge clk2) begin : predictor
        int eidx;
        eidx = cyc + 1;
        if (!rst) begin
            exp8_q.delete();
            exp4_q.delete();
            next_free    <= eidx + 1;
            out_of_reset <= 1'b1;
        end else if (out_of_reset) begin
            check("ready8", 32'(if8.ready), 32'(eidx >= next_free));
            check("ready4", 32'(if4.ready), 32'(eidx >= next_free));
            if (start && eidx >= next_free) begin
                exp8_q.push_back(model(int'(bin), 8, eidx));
                exp4_q.push_back(model(int'(bin), 4, eidx));
                next_free <= eidx + GAP;
            end
        end
        rst_at_edge <= rst;
        cyc <= eidx;
    end

    // Monitor: compares each done pulse against the queue; outputs must hold otherwise.
    always @(negedge clk2) begin : monitor
        exp_t e;
        if (out_of_reset) begin
            if (if8.done === 1'b1) begin
                if (exp8_q.size() == 0) begin
                    check("done8_unexpected", 32'(if8.done), 32'd0);
                end else begin
                    e = exp8_q.pop_front();
                    check("bcd8", if8.bcd_out, e.bcd);
                    check("ovf8", 32'(if8.ovf), 32'(e.ovf));
                    check("lat8", 32'(cyc - e.acc), 32'(LAT));
                end
            end else if (rst_at_edge) begin
                check("hold8", if8.bcd_out, prev8);
            end
            if (if4.done === 1'b1) begin
                if (exp4_q.size() == 0) begin
                    check("done4_unexpected", 32'(if4.done), 32'd0);
                end else begin
                    e = exp4_q.pop_front();
                    check("bcd4", 32'(if4.bcd_out), e.bcd);
                    check("ovf4", 32'(if4.ovf), 32'(e.ovf));
                    check("lat4", 32'(cyc - e.acc), 32'(LAT));
                end
            end else if (rst_at_edge) begin
                check("hold4", 32'(if4.bcd_out), prev4);
            end
        end
        prev8 = if8.bcd_out;
        prev4 = 32'(if4.bcd_out);
    end

    task automatic issue(input int unsigned v);
        @(negedge clk2);
        start = 1'b1;
        bin   = IN_W'(v);
        @(negedge clk2);
        start = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp8_q.size() != 0 || exp4_q.size() != 0) && n < 200) begin
            @(negedge clk2);
            n++;
        end
        if (exp8_q.size() != 0 || exp4_q.size() != 0) begin
            check("done_timeout", 32'(exp8_q.size()), 32'd0);
            exp8_q.delete();
            exp4_q.delete();
        end
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, "_ready8"}, 32'(if8.ready), 32'd1);
        check({tag, "_done8"}, 32'(if8.done), 32'd0);
        check({tag, "_bcd8"}, if8.bcd_out, 32'd0);
        check({tag, "_ovf8"}, 32'(if8.ovf), 32'd0);
        check({tag, "_ready4"}, 32'(if4.ready), 32'd1);
        check({tag, "_bcd4"}, 32'(if4.bcd_out), 32'd0);
    endtask

    initial begin
        int unsigned v;
        rst   = 1'b0;
        start = 1'b0;
        bin   = '0;
        repeat (3) @(negedge clk2);
        check_idle_reset("reset");
        rst = 1'b1;

        // Full-scale input, zero, and a value with start pulses during SHIFT.
        issue(18'h3FFFF);
        drain();
        issue(0);
        drain();
        issue(12345);
        repeat (3) @(negedge clk2);
        start = 1'b1; bin = 18'd777;
        @(negedge clk2);
        start = 1'b0;
        repeat (5) @(negedge clk2);
        start = 1'b1; bin = 18'd1;
        @(negedge clk2);
        start = 1'b0;
        drain();

        // Overflow boundaries of the 4-digit instance.
        issue(99999);
        drain();
        issue(9999);
        drain();
        issue(10000);
        drain();

        // Reset in the middle of a conversion, then a fresh conversion.
        issue(54321);
        repeat (6) @(negedge clk2);
        rst = 1'b0;
        @(negedge clk2);
        check_idle_reset("midrst");
        check("midrst_done4", 32'(if4.done), 32'd0);
        rst = 1'b1;
        repeat (LAT + 3) @(negedge clk2);
        issue(255);
        drain();

        // Start held high: back-to-back conversions every IN_W+2 cycles.
        @(negedge clk2);
        start = 1'b1;
        bin   = 18'd100;
        repeat (3 * GAP + 2) @(negedge clk2);
        start = 1'b0;
        drain();

        // Randomized values with occasional ignored start pulses while busy.
        for (int k = 0; k < 40; k++) begin
            v = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 99) : $urandom_range(0, 262143);
            issue(v);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 12)) @(negedge clk2);
                start = 1'b1;
                bin   = IN_W'($urandom);
                @(negedge clk2);
                start = 1'b0;
            end
            drain();
            repeat ($urandom_range(0, 3)) @(negedge clk2);
        end

        repeat (4) @(negedge clk2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
